// File: rtl/async_fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: pointer width and
// binary/Gray conversions used on both sides of the clock crossing.
package async_fifo_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 4;
  localparam int unsigned PTR_W          = ADDR_WIDTH_DEF + 1;

  // The conversions work on a 32-bit container. Narrower pointers are
  // zero-extended on the way in and truncated on the way out. The zero
  // upper bits do not disturb either transform.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/async_fifo_rd_ctrl_gray2bin.sv
// Combinational Gray-to-binary converter. Each binary bit is the XOR of
// all Gray bits at or above its position, built from the MSB downward.
module gray2bin #(
  parameter int SIZE = 5
) (
  input  logic [SIZE-1:0] gray,
  output logic [SIZE-1:0] bin
);

  // NOTE: every bit of bin is assigned on every pass through the block.
  // This keeps the combinational logic free of inferred latches.
  always_comb begin
    bin[SIZE-1] = gray[SIZE-1];
    for (int i = SIZE - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side pointer and flag controller for the asynchronous FIFO. It
// synchronises the Gray write pointer and drives raddr, rptr_gray,
// empty, almost_empty, rd_count and underflow.
module async_fifo_rd_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH          = 4,
  parameter int SYNC_STAGES         = 2,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   wptr_gray_async,
  input  logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  underflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AE_THRESH = PW'(ALMOST_EMPTY_THRESH);

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] wptr_sync;
  logic [PW-1:0] wbin_sync;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] count_next;
  logic          rd_fire;

  // The first flop samples the write-domain register directly. Any
  // logic ahead of it could glitch across several Gray bits.
  // NOTE: the synchroniser is a small flop chain and not a RAM, so it is
  // reset like any other register. A stale pointer must not survive a
  // reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= wptr_gray_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign wptr_sync = sync_q[SYNC_STAGES-1];

  gray2bin #(
    .SIZE (PW)
  ) u_wptr_g2b (
    .gray (wptr_sync),
    .bin  (wbin_sync)
  );

  // Reads are qualified with the registered empty. A read issued on the
  // same edge that the last entry is consumed therefore becomes an
  // underflow and never fires.
  assign rd_fire    = rd_en & ~empty;
  assign rbin_next  = rbin + {{(PW-1){1'b0}}, rd_fire};
  assign rgray_next = PW'(bin2gray(32'(rbin_next)));
  assign count_next = wbin_sync - rbin_next;

  // NOTE: state registers use non-blocking assignments. Every flop then
  // samples the pre-edge values, whatever order the statements run in.
  always_ff @(posedge clk) begin
    if (rst) begin
      rbin         <= '0;
      rptr_gray    <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_count     <= '0;
      underflow    <= 1'b0;
    end else begin
      rbin         <= rbin_next;
      rptr_gray    <= rgray_next;
      empty        <= (rgray_next == wptr_sync);
      almost_empty <= (count_next <= AE_THRESH);
      rd_count     <= count_next;
      underflow    <= rd_en & empty;
    end
  end

  assign raddr = rbin[ADDR_WIDTH-1:0];

endmodule
